// File: rtl/bitriquat_pkg.sv
// Shared types and helpers for the scheduler that fronts the NCL binary+trinary=quaternary adder.
package bitriquat_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    NULLP = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int BI_W   = 2;
  localparam int TRI_W  = 3;
  localparam int QUAT_W = 4;

  localparam logic [1:0] TRI_ILLEGAL = 2'd3;

  // Lowest-index high rail wins, so a multi-hot word still decodes deterministically.
  function automatic logic [1:0] onehot_to_bin(input logic [QUAT_W-1:0] rails);
    logic [1:0] idx;
    idx = '0;
    for (int i = QUAT_W - 1; i >= 0; i--) begin
      if (rails[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bitriquat_sched_arb.sv
// Round-robin arbiter: grants the first valid requester at or after the pointer,
// and moves the pointer past the winner when the grant is taken.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            init_n,
  input  logic [NREQ-1:0] valid_i,
  input  logic            advance_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o,
  output logic            any_o
);

  logic [IDW-1:0] ptr_q, ptr_d;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    any_o    = 1'b0;
    ptr_d    = ptr_q;
    for (int d = 0; d < NREQ; d++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!any_o && valid_i[j] && (((int'(ptr_q) + d) % NREQ) == j)) begin
          any_o    = 1'b1;
          gnt_o[j] = 1'b1;
          gnt_id_o = IDW'(j);
          ptr_d    = IDW'((j + 1) % NREQ);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      ptr_q <= '0;
    end else if (advance_i && any_o) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bitriquat_sched.sv
// Shares one clockless NCL binary+trinary adder between NREQ clocked requesters.
// Optional build macro BITRIQUAT_SCHED_ONEHOT_CHECK_EN adds multi-hot/sum checking and onehot_fault.
module bitriquat_sched
  import bitriquat_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     init_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_bi,
  input  logic [2*NREQ-1:0]        req_tri,
  output logic [NREQ-1:0]          req_ready,
  output logic [BI_W-1:0]          biin,
  output logic [TRI_W-1:0]         triin,
  output logic                     quat_en,
  input  logic [QUAT_W-1:0]        quatout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [1:0]               rsp_sum,
  output logic                     rsp_err,
`ifdef BITRIQUAT_SCHED_ONEHOT_CHECK_EN
  output logic                     onehot_fault,
`endif
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);

  state_e              state_q, state_d;
  logic                bi_q, bi_d;
  logic [1:0]          tri_q, tri_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [1:0]          sum_q, sum_d;
  logic                err_q, err_d;
  logic [7:0]          timer_q, timer_d;
  logic [BI_W-1:0]     biin_q, biin_d;
  logic [TRI_W-1:0]    triin_q, triin_d;
  logic                quat_en_q, quat_en_d;
  logic                arm_q;
  logic [QUAT_W-1:0]   sync_q [SYNC_STAGES];
  logic [QUAT_W-1:0]   qs;

  logic [NREQ-1:0]     gnt;
  logic [IDW-1:0]      gnt_id;
  logic                gnt_any;
  logic                grant_en;
  logic                sel_bi;
  logic [1:0]          sel_tri;
  logic                timeout;

`ifdef BITRIQUAT_SCHED_ONEHOT_CHECK_EN
  logic                fault_q, fault_d;
  logic                multi_hot;
  logic [1:0]          exp_sum;
  assign multi_hot    = |(qs & (qs - QUAT_W'(1)));
  assign exp_sum      = {1'b0, bi_q} + tri_q;
  assign onehot_fault = fault_q;
`endif

  // Rails from the adder are asynchronous; only the last synchronizer stage is trusted.
  assign qs       = sync_q[SYNC_STAGES-1];
  assign grant_en = (state_q == IDLE) && arm_q;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk       (clk),
    .init_n    (init_n),
    .valid_i   (req_valid),
    .advance_i (grant_en),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id),
    .any_o     (gnt_any)
  );

  always_comb begin
    state_d = state_q;
    bi_d    = bi_q;
    tri_d   = tri_q;
    id_d    = id_q;
    sum_d   = sum_q;
    err_d   = err_q;
`ifdef BITRIQUAT_SCHED_ONEHOT_CHECK_EN
    fault_d = fault_q;
`endif
    sel_bi  = 1'b0;
    sel_tri = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_bi  = req_bi[i];
        sel_tri = req_tri[2*i +: 2];
      end
    end
    timeout = ((timer_q + 8'd1) == TMO);

    case (state_q)
      IDLE: begin
        if (grant_en && gnt_any) begin
          bi_d    = sel_bi;
          tri_d   = sel_tri;
          id_d    = gnt_id;
          sum_d   = '0;
          // An illegal trinary code never reaches the adder.
          err_d   = (sel_tri == TRI_ILLEGAL);
          state_d = (sel_tri == TRI_ILLEGAL) ? RESP : DATA;
        end
      end
      DATA: begin
        if (qs != '0) begin
          sum_d   = onehot_to_bin(qs);
          state_d = NULLP;
`ifdef BITRIQUAT_SCHED_ONEHOT_CHECK_EN
          if (multi_hot || (onehot_to_bin(qs) != exp_sum)) begin
            err_d   = 1'b1;
            fault_d = 1'b1;
          end
`endif
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = NULLP;
        end
      end
      NULLP: begin
        if (qs == '0) begin
          state_d = RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Timer restarts on every phase change and only runs while waiting on the adder.
    if ((state_d != state_q) || (state_q == IDLE) || (state_q == RESP)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 8'd1;
    end

    biin_d    = '0;
    triin_d   = '0;
    quat_en_d = 1'b0;
    if (state_d == DATA) begin
      biin_d    = BI_W'(1) << bi_d;
      triin_d   = TRI_W'(1) << tri_d;
      quat_en_d = 1'b1;
    end
  end

  // Adder-facing rails are registered so the NCL inputs switch cleanly, and clear asynchronously on reset.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q   <= IDLE;
      bi_q      <= 1'b0;
      tri_q     <= '0;
      id_q      <= '0;
      sum_q     <= '0;
      err_q     <= 1'b0;
      timer_q   <= '0;
      biin_q    <= '0;
      triin_q   <= '0;
      quat_en_q <= 1'b0;
      arm_q     <= 1'b0;
`ifdef BITRIQUAT_SCHED_ONEHOT_CHECK_EN
      fault_q   <= 1'b0;
`endif
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      bi_q      <= bi_d;
      tri_q     <= tri_d;
      id_q      <= id_d;
      sum_q     <= sum_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
      biin_q    <= biin_d;
      triin_q   <= triin_d;
      quat_en_q <= quat_en_d;
      arm_q     <= 1'b1;
`ifdef BITRIQUAT_SCHED_ONEHOT_CHECK_EN
      fault_q   <= fault_d;
`endif
      sync_q[0] <= quatout;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign req_ready = gnt & {NREQ{grant_en}};
  assign biin      = biin_q;
  assign triin     = triin_q;
  assign quat_en   = quat_en_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bitriquat_sched.sv
// Directed bench for bitriquat_sched with a behavioural 3-cycle NCL adder model.
module tb_bitriquat_sched;

  logic       clk = 1'b0;
  logic       init_n = 1'b0;
  logic [1:0] req_valid = '0;
  logic [1:0] req_bi = '0;
  logic [3:0] req_tri = '0;
  logic [1:0] req_ready;
  logic [1:0] biin;
  logic [2:0] triin;
  logic       quat_en;
  logic [3:0] quatout = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [0:0] rsp_id;
  logic [1:0] rsp_sum;
  logic       rsp_err;
  logic       busy;
`ifdef BITRIQUAT_SCHED_ONEHOT_CHECK_EN
  logic       onehot_fault;
`endif

  int checks = 0;
  int errors = 0;

  bitriquat_sched #(
    .NREQ        (2),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (20)
  ) dut (
    .clk       (clk),
    .init_n    (init_n),
    .req_valid (req_valid),
    .req_bi    (req_bi),
    .req_tri   (req_tri),
    .req_ready (req_ready),
    .biin      (biin),
    .triin     (triin),
    .quat_en   (quat_en),
    .quatout   (quatout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_err   (rsp_err),
`ifdef BITRIQUAT_SCHED_ONEHOT_CHECK_EN
    .onehot_fault (onehot_fault),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Adder model: output follows the one-hot sum of its DATA inputs (or NULL) three clocks later.
  logic [3:0] m_target;
  int         m_shift;
  int         m_cnt = 0;
  logic       adder_dead = 1'b0;

  always_comb begin
    m_target = 4'b0000;
    m_shift  = (biin[1] ? 1 : 0) + (triin[2] ? 2 : (triin[1] ? 1 : 0));
    if (quat_en && (biin != 2'b00) && (triin != 3'b000)) m_target = 4'b0001 << m_shift;
  end

  always @(posedge clk) begin
    if (adder_dead || (m_target == quatout)) m_cnt <= 0;
    else if (m_cnt == 2) begin
      quatout <= m_target;
      m_cnt   <= 0;
    end else m_cnt <= m_cnt + 1;
  end

  // Runs one transaction for requester r and reports what was seen on the adder and response sides.
  task automatic do_txn(input int r, input logic b, input logic [1:0] t,
                        output logic granted, output logic responded,
                        output logic pre_null, output logic post_null,
                        output logic rail_seen, output int data_cyc,
                        output logic [1:0] d_bi, output logic [2:0] d_tri,
                        output logic [0:0] id, output logic [1:0] sum, output logic err);
    int cyc;
    granted = 0; responded = 0; pre_null = 0; post_null = 0; rail_seen = 0;
    data_cyc = 0; d_bi = '0; d_tri = '0; id = '0; sum = '0; err = 0;
    @(negedge clk);
    req_bi[r] = b;
    req_tri[2*r +: 2] = t;
    req_valid[r] = 1'b1;
    #1;
    cyc = 0;
    while (req_ready[r] !== 1'b1 && cyc < 50) begin
      @(negedge clk); #1; cyc++;
    end
    granted  = (req_ready[r] === 1'b1);
    pre_null = (biin === 2'b00) && (triin === 3'b000) && (quat_en === 1'b0);
    @(negedge clk);
    req_valid[r] = 1'b0;
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 100) begin
      if (biin !== 2'b00 || triin !== 3'b000) rail_seen = 1;
      if (quat_en === 1'b1) begin
        data_cyc++;
        d_bi  = biin;
        d_tri = triin;
      end
      @(negedge clk); cyc++;
    end
    responded = (rsp_valid === 1'b1);
    post_null = (biin === 2'b00) && (triin === 3'b000) && (quat_en === 1'b0);
    id  = rsp_id;
    sum = rsp_sum;
    err = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    init_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({biin, triin, quat_en} !== 6'b0) begin errors++; $display("FAIL reset_adder_in: got %b expected 000000", {biin, triin, quat_en}); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    checks++; if ({rsp_valid, rsp_id, rsp_sum, rsp_err} !== 5'b0) begin errors++; $display("FAIL reset_rsp: got %b expected 00000", {rsp_valid, rsp_id, rsp_sum, rsp_err}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    init_n = 1'b1;
    repeat (2) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL stray_rsp_ready: busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid); end
  endtask

  task automatic test_single();
    logic g, rs, pn, qn, rl, er;
    int dc;
    logic [1:0] db, sm;
    logic [2:0] dt;
    logic [0:0] id;
    do_txn(0, 1'b1, 2'd2, g, rs, pn, qn, rl, dc, db, dt, id, sm, er);
    checks++; if (g !== 1'b1 || rs !== 1'b1) begin errors++; $display("FAIL single_handshake: grant=%b rsp=%b expected 1 1", g, rs); end
    checks++; if (db !== 2'b10) begin errors++; $display("FAIL single_biin: got %b expected 10", db); end
    checks++; if (dt !== 3'b100) begin errors++; $display("FAIL single_triin: got %b expected 100", dt); end
    checks++; if (dc == 0) begin errors++; $display("FAIL single_quat_en: got %0d DATA cycles expected >0", dc); end
    checks++; if (qn !== 1'b1) begin errors++; $display("FAIL single_null_after: got %b expected 1", qn); end
    checks++; if (sm !== 2'd3 || er !== 1'b0 || id !== 1'b0) begin errors++; $display("FAIL single_rsp: sum=%0d err=%b id=%0d expected 3 0 0", sm, er, id); end
  endtask

  task automatic test_all_pairs();
    logic       tb_bi  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] tb_tri [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [1:0] tb_sum [6] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3};
    logic [1:0] tb_br  [6] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
    logic [2:0] tb_tr  [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic g, rs, pn, qn, rl, er;
    int dc;
    logic [1:0] db, sm;
    logic [2:0] dt;
    logic [0:0] id;
    for (int k = 0; k < 6; k++) begin
      do_txn(1, tb_bi[k], tb_tri[k], g, rs, pn, qn, rl, dc, db, dt, id, sm, er);
      checks++; if (rs !== 1'b1 || sm !== tb_sum[k] || er !== 1'b0 || id !== 1'b1)
        begin errors++; $display("FAIL pair%0d_rsp: rsp=%b sum=%0d err=%b id=%0d expected 1 %0d 0 1", k, rs, sm, er, id, tb_sum[k]); end
      checks++; if (db !== tb_br[k] || dt !== tb_tr[k])
        begin errors++; $display("FAIL pair%0d_rails: biin=%b triin=%b expected %b %b", k, db, dt, tb_br[k], tb_tr[k]); end
      checks++; if (pn !== 1'b1 || qn !== 1'b1)
        begin errors++; $display("FAIL pair%0d_null: before=%b after=%b expected 1 1", k, pn, qn); end
    end
  endtask

  task automatic test_back_to_back();
    int order [4] = '{0, 1, 0, 1};
    logic [1:0] exp_sum [2] = '{2'd1, 2'd2};
    int cyc;
    int g;
    @(negedge clk);
    req_bi    = 2'b10;
    req_tri   = 4'b0101;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      cyc = 0;
      while (req_ready === 2'b00 && cyc < 50) begin
        @(negedge clk); #1; cyc++;
      end
      g = (req_ready === 2'b10) ? 1 : ((req_ready === 2'b01) ? 0 : -1);
      checks++; if (g != order[k]) begin errors++; $display("FAIL b2b_grant%0d: got %0d expected %0d", k, g, order[k]); end
      @(negedge clk);
      cyc = 0;
      while (rsp_valid !== 1'b1 && cyc < 100) begin
        @(negedge clk); cyc++;
      end
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'(order[k]) || rsp_sum !== exp_sum[order[k]] || rsp_err !== 1'b0)
        begin errors++; $display("FAIL b2b_rsp%0d: valid=%b id=%0d sum=%0d err=%b expected 1 %0d %0d 0", k, rsp_valid, rsp_id, rsp_sum, rsp_err, order[k], exp_sum[order[k]]); end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      if (k < 3) begin
        checks++; if (req_ready === 2'b00) begin errors++; $display("FAIL b2b_regrant%0d: got %b expected a grant", k, req_ready); end
      end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_illegal();
    logic g, rs, pn, qn, rl, er;
    int dc;
    logic [1:0] db, sm;
    logic [2:0] dt;
    logic [0:0] id;
    do_txn(0, 1'b1, 2'd3, g, rs, pn, qn, rl, dc, db, dt, id, sm, er);
    checks++; if (rs !== 1'b1 || er !== 1'b1 || sm !== 2'd0) begin errors++; $display("FAIL illegal_rsp: rsp=%b err=%b sum=%0d expected 1 1 0", rs, er, sm); end
    checks++; if (dc != 0 || rl !== 1'b0 || pn !== 1'b1 || qn !== 1'b1) begin errors++; $display("FAIL illegal_null: data_cyc=%0d rails=%b expected 0 0", dc, rl); end
  endtask

  task automatic test_timeout();
    logic g, rs, pn, qn, rl, er;
    int dc;
    logic [1:0] db, sm;
    logic [2:0] dt;
    logic [0:0] id;
    adder_dead = 1'b1;
    do_txn(0, 1'b1, 2'd1, g, rs, pn, qn, rl, dc, db, dt, id, sm, er);
    adder_dead = 1'b0;
    checks++; if (dc != 20) begin errors++; $display("FAIL timeout_data_cycles: got %0d expected 20", dc); end
    checks++; if (rs !== 1'b1 || er !== 1'b1 || qn !== 1'b1) begin errors++; $display("FAIL timeout_rsp: rsp=%b err=%b null=%b expected 1 1 1", rs, er, qn); end
  endtask

  task automatic test_reset_mid();
    logic g, rs, pn, qn, rl, er, seen;
    int dc, cyc;
    logic [1:0] db, sm;
    logic [2:0] dt;
    logic [0:0] id;
    @(negedge clk);
    req_bi[0] = 1'b1;
    req_tri[1:0] = 2'd0;
    req_valid[0] = 1'b1;
    cyc = 0;
    while (quat_en !== 1'b1 && cyc < 50) begin
      @(negedge clk); cyc++;
    end
    req_valid[0] = 1'b0;
    checks++; if (quat_en !== 1'b1) begin errors++; $display("FAIL midrst_enter_data: got %b expected 1", quat_en); end
    #2 init_n = 1'b0;
    #1;
    checks++; if ({biin, triin, quat_en} !== 6'b0) begin errors++; $display("FAIL midrst_async_null: got %b expected 000000", {biin, triin, quat_en}); end
    repeat (2) @(negedge clk);
    init_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp: got rsp_valid %b expected 0", seen); end
    do_txn(1, 1'b1, 2'd2, g, rs, pn, qn, rl, dc, db, dt, id, sm, er);
    checks++; if (rs !== 1'b1 || sm !== 2'd3 || er !== 1'b0 || id !== 1'b1)
      begin errors++; $display("FAIL midrst_next_txn: rsp=%b sum=%0d err=%b id=%0d expected 1 3 0 1", rs, sm, er, id); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_pairs();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
